// File: rtl/tfacc_axi_pkg.sv
// Shared types and helpers for the tfacc AXI master arbiters: write FSM states,
// AXI response codes and the round-robin pick function.
package tfacc_axi_pkg;

  typedef enum logic [2:0] {Idle, Grant, Addr, Data, Resp} wst_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int         MAX_NP    = 16;

  // First requester strictly after 'last', wrapping at np; returns 'last' if none.
  function automatic logic [3:0] rr_next(input logic [15:0] req,
                                         input logic [3:0]  last,
                                         input int          np);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_NP; i++) begin
      idx = (int'(last) + i) % np;
      if (!found && i <= np && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: picks the first requester after the
// previously served channel.
module rr_arb
  import tfacc_axi_pkg::*;
#(
  parameter  int Np = 1,
  localparam int CW = (Np > 1) ? $clog2(Np) : 1
) (
  input  logic [Np-1:0] req,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] gnt,
  output logic          any
);

  logic [15:0] req_ext;
  logic [3:0]  pick;
  logic        unused_pick;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    req_ext         = '0;
    req_ext[Np-1:0] = req;
  end

  assign pick        = rr_next(req_ext, 4'(last), Np);
  assign gnt         = pick[CW-1:0];
  assign any         = |req;
  assign unused_pick = ^pick;

endmodule

// File: rtl/output_arb.sv
// AXI4 write-master arbiter: Np output channels take turns streaming one
// NTFR-beat burst at a time over AW/W/B. Define OUTPUT_ARB_ERR_EN for the sticky error flag.
module output_arb
  import tfacc_axi_pkg::*;
#(
  parameter int Np   = 1,
  parameter int NTFR = 64
) (
  input  logic                 aclk,
  input  logic                 arst_n,
  input  logic [Np-1:0]        wreq,
  input  logic [Np-1:0][23:0]  wadr,
  input  logic [Np-1:0][63:0]  wdata,
  output logic [Np-1:0]        wack,
  output logic [Np-1:0]        wdone,
  input  logic [31:0]          baseadr,
  output logic [39:0]          awaddr,
  output logic [7:0]           awlen,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [63:0]          wr_data,
  output logic                 wvalid,
  output logic                 wlast,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [39:0]          araddr,
  output logic [7:0]           arlen,
  output logic                 arvalid,
  output logic                 rready,
  output logic                 err
);

  localparam int Nb  = $clog2(NTFR * 8);
  localparam int CW  = (Np > 1) ? $clog2(Np) : 1;
  localparam int WCW = $clog2(NTFR);

  wst_t           mst;
  logic [CW-1:0]  ch;
  logic [CW-1:0]  rr_last;
  logic [CW-1:0]  gnt;
  logic           any_req;
  logic [WCW-1:0] wcnt;
  logic [23:0]    wpt;
  logic           beat;
  logic           last_beat;

  rr_arb #(.Np(Np)) u_rr_arb (
    .req  (wreq),
    .last (rr_last),
    .gnt  (gnt),
    .any  (any_req)
  );

  assign beat      = wvalid & wready;
  assign last_beat = (wcnt == WCW'(NTFR - 1));
  assign wlast     = wvalid & last_beat;
  assign wr_data   = wdata[ch];
  assign awlen     = 8'(NTFR - 1);
  // wpt is captured already burst-aligned; the 40-bit sum drops any carry out of bit 39.
  assign awaddr    = {16'h0000, wpt} + {8'h00, baseadr};

  assign araddr  = '0;
  assign arlen   = '0;
  assign arvalid = 1'b0;
  assign rready  = 1'b0;

  always_comb begin
    wack  = '0;
    wdone = '0;
    if (beat)                 wack[ch]  = 1'b1;
    if (mst == Resp && bvalid) wdone[ch] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      mst     <= Idle;
      ch      <= '0;
      rr_last <= CW'(Np - 1);
      wcnt    <= '0;
      wpt     <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      case (mst)
        Idle: begin
          if (any_req) begin
            ch  <= gnt;
            mst <= Grant;
          end
        end
        Grant: begin
          wpt     <= {wadr[ch][23:Nb], {Nb{1'b0}}};
          awvalid <= 1'b1;
          mst     <= Addr;
        end
        Addr: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wcnt    <= '0;
            mst     <= Data;
          end
        end
        Data: begin
          if (beat) begin
            wcnt <= wcnt + 1'b1;
            if (last_beat) begin
              wvalid <= 1'b0;
              bready <= 1'b1;
              mst    <= Resp;
            end
          end
        end
        Resp: begin
          if (bvalid) begin
            bready  <= 1'b0;
            rr_last <= ch;
            mst     <= Idle;
          end
        end
        default: mst <= Idle;
      endcase
    end
  end

`ifdef OUTPUT_ARB_ERR_EN
  logic        err_q;
  logic [15:0] err_cnt;
  logic        unused_bits;

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else if (mst == Resp && bvalid && bresp != RESP_OKAY) begin
      err_q <= 1'b1;
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign err         = err_q;
  assign unused_bits = ^{wadr, err_cnt};
`else
  logic unused_bits;

  assign err         = 1'b0;
  assign unused_bits = ^{wadr, bresp};
`endif

endmodule

// File: tb/tb_output_arb.sv
// Directed bench for output_arb (Np=4, NTFR=64): a bench-side memc slave and
// channel data models, one task per scenario.
module tb_output_arb;

  localparam int NP   = 4;
  localparam int NTFR = 64;

  typedef struct {
    int          aw_wait;
    logic [39:0] addr;
    logic [7:0]  len;
    int          beats;
    int          lasts;
    int          bad_data;
    int          bad_wack;
    int          viol;
    logic [3:0]  done;
    bit          timeout;
  } obs_t;

  logic                 aclk;
  logic                 arst_n;
  logic [NP-1:0]        wreq;
  logic [NP-1:0][23:0]  wadr;
  logic [NP-1:0][63:0]  wdata;
  logic [NP-1:0]        wack;
  logic [NP-1:0]        wdone;
  logic [31:0]          baseadr;
  logic [39:0]          awaddr;
  logic [7:0]           awlen;
  logic                 awvalid;
  logic                 awready;
  logic [63:0]          wr_data;
  logic                 wvalid;
  logic                 wlast;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [39:0]          araddr;
  logic [7:0]           arlen;
  logic                 arvalid;
  logic                 rready;
  logic                 err;

  int vectors;
  int miscompares;
  int chan_cnt [NP];

  output_arb #(.Np(NP), .NTFR(NTFR)) dut (
    .aclk    (aclk),
    .arst_n  (arst_n),
    .wreq    (wreq),
    .wadr    (wadr),
    .wdata   (wdata),
    .wack    (wack),
    .wdone   (wdone),
    .baseadr (baseadr),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awvalid (awvalid),
    .awready (awready),
    .wr_data (wr_data),
    .wvalid  (wvalid),
    .wlast   (wlast),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arlen   (arlen),
    .arvalid (arvalid),
    .rready  (rready),
    .err     (err)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Channel model: beat data carries a channel tag and the beat index within the burst.
  always @(posedge aclk) begin
    for (int c = 0; c < NP; c++) begin
      if (!arst_n)       chan_cnt[c] <= 0;
      else if (wdone[c]) chan_cnt[c] <= 0;
      else if (wack[c])  chan_cnt[c] <= chan_cnt[c] + 1;
    end
  end

  always_comb begin
    for (int c = 0; c < NP; c++)
      wdata[c] = {8'hA0 + 8'(c), 24'h0, 32'(chan_cnt[c])};
  end

  task automatic apply_reset();
    wreq    = '0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    arst_n  = 1'b0;
    repeat (3) @(negedge aclk);
    arst_n = 1'b1;
  endtask

  // memc slave for one burst; returns what it observed, comparisons are made by the callers.
  task automatic serve_burst(input int exp_ch, input int aw_stall, input bit rand_wr,
                             input logic [1:0] rsp, input int b_lat,
                             input logic [3:0] req_after, output obs_t o);
    logic [63:0] exp_d;
    logic [63:0] held;
    logic [3:0]  onehot;
    bit          stalled;
    o = '{aw_wait: 0, addr: '0, len: '0, beats: 0, lasts: 0, bad_data: 0,
          bad_wack: 0, viol: 0, done: '0, timeout: 1'b0};
    onehot  = 4'b0001 << exp_ch;
    held    = '0;
    stalled = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge aclk); #1;
      if (awvalid === 1'b1) begin
        o.aw_wait = i;
        break;
      end
    end
    if (o.aw_wait == 0) begin
      o.timeout = 1'b1;
      return;
    end
    o.addr = awaddr;
    o.len  = awlen;
    for (int k = 0; k < aw_stall; k++) begin
      @(negedge aclk); #1;
      if (awvalid !== 1'b1 || awaddr !== o.addr || wvalid !== 1'b0) o.viol++;
    end
    @(negedge aclk);
    awready = 1'b1;
    wreq    = req_after;
    for (int cyc = 0; cyc < 4000 && o.beats < NTFR; cyc++) begin
      @(negedge aclk);
      awready = 1'b0;
      wready  = rand_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (wvalid !== 1'b1) o.viol++;
      if (stalled && wr_data !== held) o.viol++;
      if (wlast !== ((o.beats == NTFR - 1) ? 1'b1 : 1'b0)) o.viol++;
      if (wvalid === 1'b1 && wready) begin
        exp_d = {8'hA0 + 8'(exp_ch), 24'h0, 32'(o.beats)};
        if (wr_data !== exp_d) o.bad_data++;
        if (wack !== onehot) o.bad_wack++;
        if (wlast === 1'b1) o.lasts++;
        o.beats++;
        stalled = 1'b0;
      end else begin
        if (wack !== 4'b0000) o.bad_wack++;
        stalled = 1'b1;
        held    = wr_data;
      end
    end
    if (o.beats < NTFR) begin
      o.timeout = 1'b1;
      return;
    end
    for (int k = 0; k < b_lat; k++) begin
      @(negedge aclk);
      wready = 1'b0;
      #1;
      if (bready !== 1'b1 || wvalid !== 1'b0 || wdone !== 4'b0000) o.viol++;
    end
    @(negedge aclk);
    bvalid = 1'b1;
    bresp  = rsp;
    #1;
    o.done = wdone;
    @(negedge aclk);
    bvalid = 1'b0;
    bresp  = 2'b00;
    #1;
    if (bready !== 1'b0 || wdone !== 4'b0000) o.viol++;
  endtask

  task automatic test_reset();
    wreq    = 4'b1111;
    awready = 1'b1;
    wready  = 1'b1;
    bvalid  = 1'b1;
    bresp   = 2'b10;
    arst_n  = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    vectors++; if (awvalid !== 1'b0) begin miscompares++; $display("FAIL reset_awvalid: got %b want 0", awvalid); end
    vectors++; if (wvalid !== 1'b0) begin miscompares++; $display("FAIL reset_wvalid: got %b want 0", wvalid); end
    vectors++; if (bready !== 1'b0) begin miscompares++; $display("FAIL reset_bready: got %b want 0", bready); end
    vectors++; if (wack !== 4'b0000) begin miscompares++; $display("FAIL reset_wack: got %b want 0000", wack); end
    vectors++; if (wdone !== 4'b0000) begin miscompares++; $display("FAIL reset_wdone: got %b want 0000", wdone); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (awlen !== 8'h3F) begin miscompares++; $display("FAIL reset_awlen: got %h want 3f", awlen); end
    vectors++; if ({araddr, arlen, arvalid, rready} !== 50'h0) begin
      miscompares++; $display("FAIL read_tieoff: got %h want 0", {araddr, arlen, arvalid, rready});
    end
    apply_reset();
  endtask

  task automatic test_single_burst();
    obs_t o;
    wadr    = '0;
    wadr[0] = 24'h001234;
    baseadr = 32'h8000_0000;
    @(negedge aclk);
    wreq = 4'b0001;
    serve_burst(0, 0, 1'b0, 2'b00, 2, 4'b0000, o);
    vectors++; if (o.timeout) begin miscompares++; $display("FAIL single_timeout: got timeout want completion"); end
    vectors++; if (o.aw_wait != 2) begin miscompares++; $display("FAIL single_aw_latency: got %0d want 2", o.aw_wait); end
    vectors++; if (o.addr !== 40'h00_8000_1200) begin miscompares++; $display("FAIL single_awaddr: got %h want 0080001200", o.addr); end
    vectors++; if (o.len !== 8'h3F) begin miscompares++; $display("FAIL single_awlen: got %h want 3f", o.len); end
    vectors++; if (o.beats != 64) begin miscompares++; $display("FAIL single_beats: got %0d want 64", o.beats); end
    vectors++; if (o.lasts != 1) begin miscompares++; $display("FAIL single_wlast: got %0d want 1", o.lasts); end
    vectors++; if (o.bad_data != 0) begin miscompares++; $display("FAIL single_data: got %0d bad beats want 0", o.bad_data); end
    vectors++; if (o.bad_wack != 0) begin miscompares++; $display("FAIL single_wack: got %0d bad cycles want 0", o.bad_wack); end
    vectors++; if (o.viol != 0) begin miscompares++; $display("FAIL single_protocol: got %0d violations want 0", o.viol); end
    vectors++; if (o.done !== 4'b0001) begin miscompares++; $display("FAIL single_wdone: got %b want 0001", o.done); end
  endtask

  task automatic test_round_robin();
    obs_t        o;
    int          ord   [5] = '{0, 1, 2, 3, 0};
    logic [39:0] exp_a [4] = '{40'h00_0001_1000, 40'h00_0002_1000, 40'h00_0003_1000, 40'h00_0004_1000};
    apply_reset();
    for (int c = 0; c < NP; c++) wadr[c] = 24'h010000 * 24'(c + 1) + 24'h0001FF;
    baseadr = 32'h0000_1000;
    wreq    = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      serve_burst(ord[b], 0, 1'b0, 2'b00, 1, (b == 4) ? 4'b0000 : 4'b1111, o);
      vectors++; if (o.timeout) begin miscompares++; $display("FAIL rr_timeout[%0d]: got timeout want completion", b); end
      vectors++; if (o.addr !== exp_a[ord[b]]) begin miscompares++; $display("FAIL rr_awaddr[%0d]: got %h want %h", b, o.addr, exp_a[ord[b]]); end
      vectors++; if (o.bad_data != 0 || o.bad_wack != 0) begin
        miscompares++; $display("FAIL rr_grant[%0d]: got %0d/%0d bad data/wack want channel %0d", b, o.bad_data, o.bad_wack, ord[b]);
      end
      vectors++; if (o.done !== (4'b0001 << ord[b])) begin miscompares++; $display("FAIL rr_wdone[%0d]: got %b want %b", b, o.done, 4'b0001 << ord[b]); end
      vectors++; if (o.viol != 0 || o.aw_wait != 2) begin
        miscompares++; $display("FAIL rr_protocol[%0d]: got %0d violations, aw wait %0d want 0, 2", b, o.viol, o.aw_wait);
      end
    end
  endtask

  task automatic test_wready_stall();
    obs_t o;
    wadr[1] = 24'h123456;
    baseadr = 32'h0;
    @(negedge aclk);
    wreq = 4'b0010;
    serve_burst(1, 0, 1'b1, 2'b00, 3, 4'b0000, o);
    vectors++; if (o.timeout) begin miscompares++; $display("FAIL stall_timeout: got timeout want completion"); end
    vectors++; if (o.addr !== 40'h00_0012_3400) begin miscompares++; $display("FAIL stall_awaddr: got %h want 0000123400", o.addr); end
    vectors++; if (o.beats != 64 || o.lasts != 1) begin miscompares++; $display("FAIL stall_beats: got %0d beats %0d wlast want 64, 1", o.beats, o.lasts); end
    vectors++; if (o.bad_data != 0) begin miscompares++; $display("FAIL stall_data: got %0d bad beats want 0", o.bad_data); end
    vectors++; if (o.bad_wack != 0) begin miscompares++; $display("FAIL stall_wack: got %0d bad cycles want 0", o.bad_wack); end
    vectors++; if (o.viol != 0) begin miscompares++; $display("FAIL stall_protocol: got %0d violations want 0", o.viol); end
    vectors++; if (o.done !== 4'b0010) begin miscompares++; $display("FAIL stall_wdone: got %b want 0010", o.done); end
  endtask

  task automatic test_aw_stall();
    obs_t o;
    wadr[0] = 24'hFFFFFF;
    baseadr = 32'hFFFF_FFFF;
    @(negedge aclk);
    wreq = 4'b0001;
    serve_burst(0, 10, 1'b0, 2'b00, 1, 4'b0000, o);
    vectors++; if (o.timeout) begin miscompares++; $display("FAIL awstall_timeout: got timeout want completion"); end
    vectors++; if (o.addr !== 40'h01_00FF_FDFF) begin miscompares++; $display("FAIL awstall_awaddr: got %h want 0100fffdff", o.addr); end
    vectors++; if (o.viol != 0) begin miscompares++; $display("FAIL awstall_protocol: got %0d violations want 0", o.viol); end
    vectors++; if (o.beats != 64 || o.bad_data != 0) begin
      miscompares++; $display("FAIL awstall_burst: got %0d beats %0d bad want 64, 0", o.beats, o.bad_data);
    end
  endtask

  task automatic test_err();
    obs_t        o;
    logic [1:0]  rsp  [3] = '{2'b00, 2'b10, 2'b00};
    logic        want [3];
    logic        exp_err;
`ifdef OUTPUT_ARB_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    want = '{1'b0, exp_err, exp_err};
    apply_reset();
    wadr[0] = 24'h000400;
    baseadr = 32'h0;
    for (int b = 0; b < 3; b++) begin
      @(negedge aclk);
      wreq = 4'b0001;
      serve_burst(0, 0, 1'b0, rsp[b], 1, 4'b0000, o);
      vectors++; if (o.timeout || o.done !== 4'b0001) begin
        miscompares++; $display("FAIL err_burst[%0d]: got wdone %b timeout %0d want 0001, 0", b, o.done, o.timeout);
      end
      repeat (2) @(negedge aclk);
      #1;
      vectors++; if (err !== want[b]) begin miscompares++; $display("FAIL err_flag[%0d]: got %b want %b", b, err, want[b]); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   nb;
    int   found;
    apply_reset();
    wadr[0] = 24'h000200;
    baseadr = 32'h0;
    nb      = 0;
    found   = 0;
    @(negedge aclk);
    wreq = 4'b0001;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge aclk); #1;
      if (awvalid === 1'b1) found = 1;
    end
    @(negedge aclk);
    awready = 1'b1;
    for (int cyc = 0; cyc < 200 && found == 1; cyc++) begin
      @(negedge aclk);
      awready = 1'b0;
      wready  = 1'b1;
      if (nb == 20) begin
        arst_n = 1'b0;
        break;
      end
      #1;
      if (wvalid === 1'b1) nb++;
    end
    vectors++; if (nb != 20) begin miscompares++; $display("FAIL midrst_reach: got %0d beats want 20", nb); end
    @(negedge aclk); #1;
    vectors++; if ({awvalid, wvalid, bready} !== 3'b000) begin
      miscompares++; $display("FAIL midrst_outputs: got awvalid/wvalid/bready %b want 000", {awvalid, wvalid, bready});
    end
    vectors++; if (wack !== 4'b0000 || wdone !== 4'b0000) begin
      miscompares++; $display("FAIL midrst_strobes: got wack %b wdone %b want 0000", wack, wdone);
    end
    arst_n = 1'b1;
    wready = 1'b0;
    serve_burst(0, 0, 1'b0, 2'b00, 1, 4'b0000, o);
    vectors++; if (o.aw_wait != 2) begin miscompares++; $display("FAIL midrst_restart: got aw wait %0d want 2", o.aw_wait); end
    vectors++; if (o.timeout || o.beats != 64 || o.bad_data != 0 || o.done !== 4'b0001) begin
      miscompares++; $display("FAIL midrst_burst: got %0d beats %0d bad wdone %b want 64, 0, 0001", o.beats, o.bad_data, o.done);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    wadr        = '0;
    baseadr     = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_wready_stall();
    test_aw_stall();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
